// File: rtl/map_store_ctrl_pkg.sv
// Shared types for the maze tile-map store: FSM states, cell codes, default geometry
// and the generator for the default maze layout held in ROM.
package map_store_ctrl_pkg;

  localparam int unsigned DEF_MAP_W  = 20;
  localparam int unsigned DEF_MAP_H  = 21;
  localparam int unsigned DEF_CELL_W = 3;
  localparam int unsigned DEF_XY_W   = 5;
  localparam int unsigned DEF_CNT_W  = 9;

  typedef enum logic [2:0] {
    CELL_EMPTY  = 3'd0,
    CELL_PELLET = 3'd1,
    CELL_WALL   = 3'd2,
    CELL_POWER  = 3'd3,
    CELL_DOOR   = 3'd4
  } cell_e;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_OUT  = 3'd3,
    ST_WR_RD   = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_WR_WR   = 3'd6
  } state_e;

  // Default maze: walled border, pellet corridors on odd rows (last three columns hold
  // a power pellet between two empties), wall posts on odd columns of even rows.
  function automatic cell_e default_cell(int unsigned x, int unsigned y,
                                         int unsigned w, int unsigned h);
    if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return CELL_WALL;
    if ((y % 2) == 1) begin
      if (x + 4 <= w - 1) return CELL_PELLET;
      if (x == w - 3) return CELL_POWER;
      return CELL_EMPTY;
    end
    return ((x % 2) == 1) ? CELL_WALL : CELL_EMPTY;
  endfunction

endpackage

// File: rtl/map_store_ctrl_rom.sv
// Default maze ROM: constant contents from the package generator, one-cycle
// registered read so it maps onto a block ROM.
module map_default_rom
  import map_store_ctrl_pkg::*;
#(
  parameter int unsigned MAP_W  = DEF_MAP_W,
  parameter int unsigned MAP_H  = DEF_MAP_H,
  parameter int unsigned CELL_W = DEF_CELL_W,
  parameter int unsigned AW     = 9
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     addr_i,
  output logic [CELL_W-1:0] data_o
);

  localparam int unsigned N = MAP_W * MAP_H;

  logic [CELL_W-1:0] rom_mem [N];
  logic [CELL_W-1:0] data_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    assign rom_mem[gi] = CELL_W'(default_cell(unsigned'(gi) % MAP_W, unsigned'(gi) / MAP_W,
                                              MAP_W, MAP_H));
  end

  always_ff @(posedge clk_i) begin
    data_q <= rom_mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/map_store_ctrl.sv
// Tile-map store: map RAM restored from the default ROM, one read client and one
// read-modify-write client, plus a live pellet counter for level-clear detection.
module map_store_ctrl
  import map_store_ctrl_pkg::*;
#(
  parameter int unsigned       MAP_W       = DEF_MAP_W,
  parameter int unsigned       MAP_H       = DEF_MAP_H,
  parameter int unsigned       CELL_W      = DEF_CELL_W,
  parameter logic [CELL_W-1:0] PELLET_CODE = CELL_W'(CELL_PELLET),
  parameter int unsigned       XY_W        = DEF_XY_W,
  parameter int unsigned       CNT_W       = DEF_CNT_W
) (
  input  logic              clock_50,
  input  logic              reset_n,
  input  logic              init_req,
  output logic              busy,
  input  logic              rd_req,
  input  logic [XY_W-1:0]   rd_x,
  input  logic [XY_W-1:0]   rd_y,
  output logic              rd_valid,
  output logic [CELL_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [XY_W-1:0]   wr_x,
  input  logic [XY_W-1:0]   wr_y,
  input  logic [CELL_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [CELL_W-1:0] wr_old,
  output logic              oob_err,
  output logic [CNT_W-1:0]  pellets_left
);

  localparam int unsigned       N       = MAP_W * MAP_H;
  localparam int unsigned       AW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned       SW      = $clog2(N + 1);
  localparam logic [SW-1:0]     SWEEP_N = SW'(N);
  localparam logic [SW-1:0]     SWEEP_1 = SW'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N);
  localparam logic [CNT_W-1:0]  CNT_1   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [SW-1:0]     sweep_q, sweep_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CELL_W-1:0] wdata_q, wdata_d;
  logic              oob_q, oob_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CELL_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ack_q, wr_ack_d;
  logic [CELL_W-1:0] wr_old_q, wr_old_d;
  logic              oob_err_q, oob_err_d;

  logic [AW-1:0]     rom_addr;
  logic [CELL_W-1:0] rom_data;

  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [CELL_W-1:0] ram_wdata;
  logic [CELL_W-1:0] ram_rd_q;
  logic [CELL_W-1:0] ram_mem [N];

  logic              rd_oob, wr_oob;
  logic [AW-1:0]     rd_addr, wr_addr;

  assign rd_oob  = (32'(rd_x) >= MAP_W) || (32'(rd_y) >= MAP_H);
  assign wr_oob  = (32'(wr_x) >= MAP_W) || (32'(wr_y) >= MAP_H);
  assign rd_addr = AW'(32'(rd_y) * MAP_W + 32'(rd_x));
  assign wr_addr = AW'(32'(wr_y) * MAP_W + 32'(wr_x));

  map_default_rom #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .CELL_W(CELL_W),
    .AW    (AW)
  ) u_rom (
    .clk_i (clock_50),
    .addr_i(rom_addr),
    .data_o(rom_data)
  );

  // Single-port map RAM; the read register only loads when a read is issued so the
  // old value survives the wait state of a read-modify-write.
  always_ff @(posedge clock_50) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rd_q <= ram_mem[ram_addr];
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oob_d      = oob_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_ack_d   = 1'b0;
    wr_old_d   = wr_old_q;
    oob_err_d  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = addr_q;
    ram_wdata  = wdata_q;
    rom_addr   = '0;

    unique case (state_q)
      // Sweep step s fetches ROM[s] and writes the ROM word fetched at step s-1.
      ST_INIT: begin
        if (sweep_q < SWEEP_N) rom_addr = AW'(sweep_q);
        if (sweep_q != '0) begin
          ram_we    = 1'b1;
          ram_addr  = AW'(sweep_q - SWEEP_1);
          ram_wdata = rom_data;
          if (rom_data == PELLET_CODE && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_1;
        end
        if (sweep_q == SWEEP_N) state_d = ST_IDLE;
        else                    sweep_d = sweep_q + SWEEP_1;
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
          sweep_d = '0;
          cnt_d   = '0;
        end else if (!(rd_valid_q || wr_ack_q)) begin
          // The completion cycle never accepts, so a still-held request is not re-run.
          if (wr_req) begin
            state_d = ST_WR_RD;
            addr_d  = wr_addr;
            wdata_d = wr_data;
            oob_d   = wr_oob;
          end else if (rd_req) begin
            state_d = ST_RD_WAIT;
            addr_d  = rd_addr;
            oob_d   = rd_oob;
          end
        end
      end
      ST_RD_WAIT: begin
        ram_re  = !oob_q;
        state_d = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        state_d    = ST_IDLE;
        rd_valid_d = 1'b1;
        oob_err_d  = oob_q;
        rd_data_d  = oob_q ? '0 : ram_rd_q;
      end
      ST_WR_RD: begin
        ram_re  = !oob_q;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        state_d = ST_WR_WR;
      end
      ST_WR_WR: begin
        state_d   = ST_IDLE;
        wr_ack_d  = 1'b1;
        oob_err_d = oob_q;
        wr_old_d  = oob_q ? '0 : ram_rd_q;
        if (!oob_q) begin
          ram_we = 1'b1;
          if (ram_rd_q == PELLET_CODE && wdata_q != PELLET_CODE && cnt_q != '0)
            cnt_d = cnt_q - CNT_1;
          else if (ram_rd_q != PELLET_CODE && wdata_q == PELLET_CODE && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_1;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oob_q      <= 1'b0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      wr_old_q   <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oob_q      <= oob_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      wr_old_q   <= wr_old_d;
      oob_err_q  <= oob_err_d;
    end
  end

  assign busy         = (state_q == ST_INIT);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign wr_ack       = wr_ack_q;
  assign wr_old       = wr_old_q;
  assign oob_err      = oob_err_q;
  assign pellets_left = cnt_q;

endmodule

// File: tb/tb_map_store_ctrl.sv
// Directed bench for map_store_ctrl on the 20x21 default maze (150 pellets), with the
// expected maze drawn row by row as text.
module tb_map_store_ctrl;

  localparam int MAP_W = 20;
  localparam int MAP_H = 21;
  localparam int CELL_W = 3;
  localparam int XY_W = 5;
  localparam int CNT_W = 9;
  localparam int EXP_PELLETS = 150;
  localparam int EXP_SWEEP = 421;

  logic              clock_50 = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_req = 1'b0;
  logic              busy;
  logic              rd_req = 1'b0;
  logic [XY_W-1:0]   rd_x = '0;
  logic [XY_W-1:0]   rd_y = '0;
  logic              rd_valid;
  logic [CELL_W-1:0] rd_data;
  logic              wr_req = 1'b0;
  logic [XY_W-1:0]   wr_x = '0;
  logic [XY_W-1:0]   wr_y = '0;
  logic [CELL_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic [CELL_W-1:0] wr_old;
  logic              oob_err;
  logic [CNT_W-1:0]  pellets_left;

  int total = 0;
  int bad = 0;
  string rows[MAP_H];

  map_store_ctrl #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .CELL_W(CELL_W), .PELLET_CODE(3'd1),
    .XY_W(XY_W), .CNT_W(CNT_W)
  ) dut (
    .clock_50(clock_50), .reset_n(reset_n), .init_req(init_req), .busy(busy),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_old(wr_old), .oob_err(oob_err), .pellets_left(pellets_left)
  );

  always #5 clock_50 = ~clock_50;

  // '#' wall=2, '.' pellet=1, 'o' power=3, ' ' empty=0
  task automatic build_map();
    for (int y = 0; y < MAP_H; y++) begin
      if (y == 0 || y == MAP_H - 1) rows[y] = {"#####", "#####", "#####", "#####"};
      else if (y % 2 == 1)          rows[y] = {"#", ".....", ".....", ".....", " o ", "#"};
      else                          rows[y] = {"#", "# # # ", "# # # ", "# # # ", "#"};
    end
  endtask

  function automatic logic [2:0] exp_cell(int x, int y);
    byte c;
    c = rows[y].getc(x);
    case (c)
      "#": return 3'd2;
      ".": return 3'd1;
      "o": return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  task automatic count_busy(output int c);
    c = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clock_50); #1;
      if (!busy) begin c = n; break; end
    end
  endtask

  task automatic do_read(input int x, input int y, input bit verbose,
                         output logic [2:0] data, output logic oob, output int lat);
    @(posedge clock_50); #1;
    rd_x = XY_W'(x); rd_y = XY_W'(y); rd_req = 1'b1;
    lat = -1; data = '0; oob = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clock_50); #1;
      if (rd_valid) begin lat = n - 1; data = rd_data; oob = oob_err; break; end
    end
    rd_req = 1'b0;
    if (verbose) $display("rd (%0d,%0d) data=%0d oob=%0b lat=%0d", x, y, data, oob, lat);
  endtask

  task automatic do_write(input int x, input int y, input logic [2:0] d,
                          output logic [2:0] old, output logic oob, output int lat);
    @(posedge clock_50); #1;
    wr_x = XY_W'(x); wr_y = XY_W'(y); wr_data = d; wr_req = 1'b1;
    lat = -1; old = '0; oob = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clock_50); #1;
      if (wr_ack) begin lat = n - 1; old = wr_old; oob = oob_err; break; end
    end
    wr_req = 1'b0;
    $display("wr (%0d,%0d)=%0d old=%0d oob=%0b lat=%0d pellets=%0d", x, y, d, old, oob, lat,
             pellets_left);
  endtask

  task automatic test_reset();
    int c;
    reset_n = 1'b0;
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    total++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || wr_ack !== 1'b0 || oob_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl busy=%b rd_valid=%b wr_ack=%b oob_err=%b required 1 0 0 0",
               busy, rd_valid, wr_ack, oob_err);
    end
    total++;
    if (pellets_left !== '0 || rd_data !== '0 || wr_old !== '0) begin
      bad++;
      $display("FAIL reset_data pellets=%0d rd_data=%0d wr_old=%0d required 0 0 0",
               pellets_left, rd_data, wr_old);
    end
    reset_n = 1'b1;
    count_busy(c);
    $display("reset sweep busy_cycles=%0d pellets=%0d", c, pellets_left);
    total++;
    if (c !== EXP_SWEEP) begin
      bad++; $display("FAIL reset_sweep_len got %0d required %0d", c, EXP_SWEEP);
    end
    total++;
    if (pellets_left !== CNT_W'(EXP_PELLETS)) begin
      bad++; $display("FAIL reset_pellets got %0d required %0d", pellets_left, EXP_PELLETS);
    end
  endtask

  task automatic test_ram_matches_rom(input string tag);
    int errs, fx, fy, lat;
    logic [2:0] d, fgot;
    logic o;
    errs = 0; fx = 0; fy = 0; fgot = '0;
    for (int y = 0; y < MAP_H; y++) begin
      for (int x = 0; x < MAP_W; x++) begin
        do_read(x, y, 1'b0, d, o, lat);
        if (d !== exp_cell(x, y) || o !== 1'b0 || lat !== 2) begin
          if (errs == 0) begin fx = x; fy = y; fgot = d; end
          errs++;
        end
      end
    end
    $display("map scan %s mismatches=%0d", tag, errs);
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s mismatches=%0d required 0 (first x=%0d y=%0d got %0d want %0d)",
               tag, errs, fx, fy, fgot, exp_cell(fx, fy));
    end
  endtask

  task automatic test_read();
    logic [2:0] d;
    logic o;
    int lat;
    do_read(3, 2, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd2 || o !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL read_wall data=%0d oob=%0b lat=%0d required 2 0 2", d, o, lat);
    end
    do_read(17, 1, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd3 || o !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL read_power data=%0d oob=%0b lat=%0d required 3 0 2", d, o, lat);
    end
    do_read(19, 20, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd2 || o !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL read_corner data=%0d oob=%0b lat=%0d required 2 0 2", d, o, lat);
    end
  endtask

  task automatic test_write();
    logic [2:0] old, d;
    logic o;
    int lat;
    do_write(5, 1, 3'd0, old, o, lat);
    total++;
    if (old !== 3'd1 || o !== 1'b0 || lat !== 3 || pellets_left !== CNT_W'(149)) begin
      bad++;
      $display("FAIL eat_pellet old=%0d oob=%0b lat=%0d pellets=%0d required 1 0 3 149",
               old, o, lat, pellets_left);
    end
    do_read(5, 1, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd0) begin
      bad++; $display("FAIL eaten_readback got %0d required 0", d);
    end
    do_write(5, 1, 3'd1, old, o, lat);
    total++;
    if (old !== 3'd0 || pellets_left !== CNT_W'(150)) begin
      bad++; $display("FAIL restore_pellet old=%0d pellets=%0d required 0 150", old, pellets_left);
    end
    do_write(3, 2, 3'd2, old, o, lat);
    total++;
    if (old !== 3'd2 || lat !== 3 || pellets_left !== CNT_W'(150)) begin
      bad++;
      $display("FAIL wall_over_wall old=%0d lat=%0d pellets=%0d required 2 3 150",
               old, lat, pellets_left);
    end
    do_write(2, 2, 3'd1, old, o, lat);
    total++;
    if (old !== 3'd0 || pellets_left !== CNT_W'(151)) begin
      bad++; $display("FAIL add_pellet old=%0d pellets=%0d required 0 151", old, pellets_left);
    end
    do_write(2, 2, 3'd0, old, o, lat);
    total++;
    if (old !== 3'd1 || pellets_left !== CNT_W'(150)) begin
      bad++; $display("FAIL remove_pellet old=%0d pellets=%0d required 1 150", old, pellets_left);
    end
  endtask

  task automatic test_back_to_back();
    int ack_n, val_n, lat;
    logic [2:0] old, d;
    logic o;
    @(posedge clock_50); #1;
    wr_x = 5'd7; wr_y = 5'd3; wr_data = 3'd4; rd_x = 5'd7; rd_y = 5'd3;
    wr_req = 1'b1; rd_req = 1'b1;
    ack_n = -1; val_n = -1; old = '0; d = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock_50); #1;
      if (wr_ack && ack_n < 0) begin ack_n = n; old = wr_old; wr_req = 1'b0; end
      if (rd_valid && val_n < 0) begin val_n = n; d = rd_data; rd_req = 1'b0; end
      if (val_n > 0) break;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    $display("rd+wr (7,3) ack_edge=%0d old=%0d valid_edge=%0d data=%0d", ack_n, old, val_n, d);
    total++;
    if (ack_n !== 4 || old !== 3'd1) begin
      bad++; $display("FAIL simul_write ack_edge=%0d old=%0d required 4 1", ack_n, old);
    end
    total++;
    if (val_n !== 8 || d !== 3'd4) begin
      bad++; $display("FAIL simul_read valid_edge=%0d data=%0d required 8 4", val_n, d);
    end
    total++;
    if (pellets_left !== CNT_W'(149)) begin
      bad++; $display("FAIL simul_pellets got %0d required 149", pellets_left);
    end
    do_write(7, 3, 3'd1, old, o, lat);
    total++;
    if (old !== 3'd4 || pellets_left !== CNT_W'(150)) begin
      bad++; $display("FAIL simul_restore old=%0d pellets=%0d required 4 150", old, pellets_left);
    end
  endtask

  task automatic test_oob();
    logic [2:0] d, old;
    logic o;
    int lat;
    do_read(20, 0, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd0 || o !== 1'b1 || lat !== 2) begin
      bad++; $display("FAIL oob_read data=%0d oob=%0b lat=%0d required 0 1 2", d, o, lat);
    end
    do_write(0, 21, 3'd1, old, o, lat);
    total++;
    if (old !== 3'd0 || o !== 1'b1 || lat !== 3 || pellets_left !== CNT_W'(150)) begin
      bad++;
      $display("FAIL oob_write_y old=%0d oob=%0b lat=%0d pellets=%0d required 0 1 3 150",
               old, o, lat, pellets_left);
    end
    // x=20,y=0 would alias onto (0,1) if the range check were skipped
    do_write(20, 0, 3'd1, old, o, lat);
    total++;
    if (old !== 3'd0 || o !== 1'b1 || pellets_left !== CNT_W'(150)) begin
      bad++;
      $display("FAIL oob_write_x old=%0d oob=%0b pellets=%0d required 0 1 150",
               old, o, pellets_left);
    end
    do_read(0, 1, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd2 || o !== 1'b0) begin
      bad++; $display("FAIL oob_no_alias data=%0d oob=%0b required 2 0", d, o);
    end
  endtask

  task automatic test_reset_mid_write();
    bit acked;
    int c, lat;
    logic [2:0] d;
    logic o;
    acked = 1'b0;
    @(posedge clock_50); #1;
    wr_x = 5'd5; wr_y = 5'd1; wr_data = 3'd0; wr_req = 1'b1;
    @(posedge clock_50); #1;
    @(posedge clock_50); #1;
    reset_n = 1'b0; wr_req = 1'b0;
    repeat (4) begin
      @(posedge clock_50); #1;
      if (wr_ack) acked = 1'b1;
    end
    @(negedge clock_50);
    reset_n = 1'b1;
    count_busy(c);
    $display("reset mid-write acked=%0b busy_cycles=%0d pellets=%0d", acked, c, pellets_left);
    total++;
    if (acked !== 1'b0) begin
      bad++; $display("FAIL abort_no_ack got %0b required 0", acked);
    end
    total++;
    if (c !== EXP_SWEEP || pellets_left !== CNT_W'(EXP_PELLETS)) begin
      bad++;
      $display("FAIL abort_resweep cycles=%0d pellets=%0d required %0d %0d",
               c, pellets_left, EXP_SWEEP, EXP_PELLETS);
    end
    do_read(5, 1, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd1) begin
      bad++; $display("FAIL abort_cell got %0d required 1", d);
    end
  endtask

  task automatic test_init_req();
    logic [2:0] old, d;
    logic o;
    int lat, c;
    for (int x = 1; x <= 10; x++) do_write(x, 3, 3'd0, old, o, lat);
    total++;
    if (pellets_left !== CNT_W'(140)) begin
      bad++; $display("FAIL ten_eaten got %0d required 140", pellets_left);
    end
    @(posedge clock_50); #1;
    @(posedge clock_50); #1;
    init_req = 1'b1;
    @(posedge clock_50); #1;
    init_req = 1'b0;
    total++;
    if (busy !== 1'b1 || pellets_left !== '0) begin
      bad++; $display("FAIL init_start busy=%b pellets=%0d required 1 0", busy, pellets_left);
    end
    c = -1;
    for (int n = 1; n <= 1000; n++) begin
      init_req = (n == 100);
      @(posedge clock_50); #1;
      if (!busy) begin c = n; break; end
    end
    init_req = 1'b0;
    $display("init_req sweep busy_cycles=%0d pellets=%0d", c, pellets_left);
    total++;
    if (c !== EXP_SWEEP || pellets_left !== CNT_W'(EXP_PELLETS)) begin
      bad++;
      $display("FAIL init_sweep cycles=%0d pellets=%0d required %0d %0d",
               c, pellets_left, EXP_SWEEP, EXP_PELLETS);
    end
    do_read(1, 3, 1'b1, d, o, lat);
    total++;
    if (d !== 3'd1) begin
      bad++; $display("FAIL init_restored got %0d required 1", d);
    end
  endtask

  initial begin
    build_map();
    test_reset();
    test_ram_matches_rom("map_after_reset");
    test_read();
    test_write();
    test_back_to_back();
    test_oob();
    test_reset_mid_write();
    test_init_req();
    test_ram_matches_rom("map_after_init");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
